frv_pipeline_stage_fifo: RTL and testbench
==========================================

FRV_PIPELINE_STAGE_FIFO -- requirements
Module: frv_pipeline_stage_fifo

Interface
REQ-001 Parameter: WIDTH, 32, payload width in bits (>=1).
REQ-002 Parameter: DEPTH, 2, number of buffer entries (>=1, any integer, not restricted to powers of two).
REQ-003 Parameter: PASSTHRU, 0, 0 = registered output only; 1 = same-cycle bypass when empty.
REQ-004 Parameter: CW, $clog2(DEPTH+1), occupancy count width.
REQ-005 Port: g_clk  input  1  global clock; all state SHALL change only on its rising edge.
REQ-006 Port: g_resetn  input  1  reset, synchronous and active-low.
REQ-007 Port: flush  input  1  discard all buffered entries.
REQ-008 Port: i_valid  input  1  upstream payload valid.
REQ-009 Port: i_busy  output  1  stage cannot accept a payload this cycle.
REQ-010 Port: i_data  input  WIDTH  upstream payload.
REQ-011 Port: o_valid  output  1  downstream payload valid.
REQ-012 Port: o_busy  input  1  downstream cannot accept a payload this cycle.
REQ-013 Port: o_data  output  WIDTH  downstream payload (head entry, or i_data when bypassing).
REQ-014 Port: o_count  output  CW  current number of buffered entries.

Function
REQ-015 Input transfer SHALL occur when i_valid && !i_busy; output transfer SHALL occur when o_valid && !o_busy.
REQ-016 i_busy SHALL equal (o_count == DEPTH); it SHALL have no combinational path from o_busy, so a full FIFO refuses input even when a pop occurs in the same cycle.
REQ-017 Storage SHALL be a circular buffer with read and write pointers; each pointer SHALL increment on its transfer and wrap from DEPTH-1 to 0.
REQ-018 o_count SHALL increment by 1 on push-only, decrement by 1 on pop-only, and hold on simultaneous push and pop or on no transfer.
REQ-019 With PASSTHRU=0: o_valid = (o_count != 0) and o_data = the head entry; latency from input transfer to o_valid SHALL be exactly 1 cycle.
REQ-020 With PASSTHRU=1 and o_count==0: o_valid SHALL equal i_valid and o_data SHALL equal i_data combinationally; if o_busy==0, the payload SHALL pass through, no entry is written, and o_count stays 0.
REQ-021 With PASSTHRU=1 and o_count==0 and o_busy==1: an accepted payload SHALL be written, and o_count SHALL be 1 next cycle.
REQ-022 With PASSTHRU=1 and o_count!=0: behaviour SHALL be identical to PASSTHRU=0, so ordering is preserved.
REQ-023 Payload order SHALL be strictly FIFO; no entry SHALL be duplicated or dropped except by flush.
REQ-024 When flush==1, the next cycle SHALL have o_count=0 and both pointers=0; any input transfer in the flush cycle SHALL be discarded.
REQ-025 When flush==1, o_valid SHALL be forced 0 in the same cycle in both modes, so no output transfer occurs.
REQ-026 flush and g_resetn SHALL take priority over simultaneous push and pop.
REQ-027 DEPTH=1 SHALL be legal: the block acts as a single stage register; pointers are constant 0 and i_busy = full.

Reset
REQ-028 While g_resetn==0 at a clock edge, the next state SHALL be: o_count=0, pointers=0, all storage entries=0.
REQ-029 After reset, o_valid SHALL be 0 and i_busy SHALL be 0.
REQ-030 o_data SHALL be 0 after reset with PASSTHRU=0; with PASSTHRU=1, o_data SHALL follow i_data.
REQ-031 A reset asserted mid-stream SHALL discard all entries exactly as flush does, and any transfer in that cycle SHALL be ignored.

Verification
REQ-032 Fill/drain (DEPTH=2, PASSTHRU=0): push 0xA,0xB with o_busy=1 -> o_count=2, i_busy=1; a third push is refused; release o_busy -> outputs 0xA then 0xB, o_count returns to 0.
REQ-033 Wrap (DEPTH=3): 10 pushes of 1..10 with continuous pops -> output sequence 1..10 in order, o_count<=1 throughout, no loss at pointer wrap.
REQ-034 Simultaneous push and pop at o_count=1 -> o_count stays 1 and the head advances; at o_count=DEPTH, i_busy=1 despite o_busy=0.
REQ-035 Bypass (PASSTHRU=1): empty FIFO, i_valid=1, i_data=0x55, o_busy=0 -> o_valid=1, o_data=0x55 the same cycle, o_count stays 0; repeat with o_busy=1 -> o_count=1 next cycle.
REQ-036 Flush with o_count=2 plus a concurrent push -> next cycle o_count=0, o_valid=0; the pushed payload never appears.
REQ-037 Reset asserted with o_count=2 -> next cycle o_count=0, o_valid=0, i_busy=0, o_data=0 (PASSTHRU=0).

Source files
------------

// File: rtl/frv_pipeline_stage_fifo.sv
// Pipeline stage buffer: circular FIFO with optional same-cycle bypass.
// Busy is derived from occupancy only, so it never depends on o_busy.
module frv_pipeline_stage_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int PASSTHRU = 0,
  parameter int CW       = $clog2(DEPTH+1)
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             flush,
  input  logic             i_valid,
  output logic             i_busy,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             o_busy,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_rd;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_bypass = (PASSTHRU != 0) && w_empty;

  assign i_busy  = w_full;
  assign o_count = r_count;

  always_comb begin
    o_valid = 1'b0;
    o_data  = r_mem[r_rptr];
    if (w_bypass) begin
      o_valid = i_valid;
      o_data  = i_data;
    end else begin
      o_valid = !w_empty;
    end
    if (flush) o_valid = 1'b0;
  end

  assign w_push = i_valid && !i_busy;
  assign w_pop  = o_valid && !o_busy;
  // A bypassed payload that is consumed never touches storage
  assign w_wr   = w_push && !(w_bypass && w_pop);
  assign w_rd   = w_pop && !w_bypass;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
      end
      if (w_rd) begin
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
      end
      if (w_wr && !w_rd) r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_frv_pipeline_stage_fifo.sv
// Directed bench for frv_pipeline_stage_fifo in three configurations:
// A = DEPTH 2 registered, B = DEPTH 3 registered, C = DEPTH 2 bypass.
module tb_frv_pipeline_stage_fifo;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_fl, a_iv, a_ib, a_ov, a_ob;
  logic [7:0] a_id, a_od;
  logic [1:0] a_cnt;
  logic       b_fl, b_iv, b_ib, b_ov, b_ob;
  logic [7:0] b_id, b_od;
  logic [1:0] b_cnt;
  logic       c_fl, c_iv, c_ib, c_ov, c_ob;
  logic [7:0] c_id, c_od;
  logic [1:0] c_cnt;

  frv_pipeline_stage_fifo #(.WIDTH(8), .DEPTH(2), .PASSTHRU(0)) u_a (
    .g_clk(clk), .g_resetn(rstn), .flush(a_fl),
    .i_valid(a_iv), .i_busy(a_ib), .i_data(a_id),
    .o_valid(a_ov), .o_busy(a_ob), .o_data(a_od), .o_count(a_cnt));

  frv_pipeline_stage_fifo #(.WIDTH(8), .DEPTH(3), .PASSTHRU(0)) u_b (
    .g_clk(clk), .g_resetn(rstn), .flush(b_fl),
    .i_valid(b_iv), .i_busy(b_ib), .i_data(b_id),
    .o_valid(b_ov), .o_busy(b_ob), .o_data(b_od), .o_count(b_cnt));

  frv_pipeline_stage_fifo #(.WIDTH(8), .DEPTH(2), .PASSTHRU(1)) u_c (
    .g_clk(clk), .g_resetn(rstn), .flush(c_fl),
    .i_valid(c_iv), .i_busy(c_ib), .i_data(c_id),
    .o_valid(c_ov), .o_busy(c_ob), .o_data(c_od), .o_count(c_cnt));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_fl, a_iv, a_ob, a_id} = '0;
    {b_fl, b_iv, b_ob, b_id} = '0;
    {c_fl, c_iv, c_ob, c_id} = '0;
    step();
    step();
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_ov", 32'(a_ov), 0);
    chk("rst_ib", 32'(a_ib), 0);
    chk("rst_od", 32'(a_od), 0);
    rstn = 1'b1;
    c_id = 8'h3C;
    #1;
    chk("rst_c_follow", 32'(c_od), 32'h3C);

    // fill and drain
    a_ob = 1; a_iv = 1; a_id = 8'h0A;
    step();
    chk("fill1_cnt", 32'(a_cnt), 1);
    chk("fill1_ov", 32'(a_ov), 1);
    chk("fill1_od", 32'(a_od), 32'h0A);
    a_id = 8'h0B;
    step();
    chk("fill2_cnt", 32'(a_cnt), 2);
    chk("fill2_ib", 32'(a_ib), 1);
    a_id = 8'h0C;
    step();
    chk("refuse_cnt", 32'(a_cnt), 2);
    chk("refuse_od", 32'(a_od), 32'h0A);
    a_iv = 0; a_ob = 0;
    step();
    chk("drain1_od", 32'(a_od), 32'h0B);
    chk("drain1_cnt", 32'(a_cnt), 1);
    step();
    chk("drain2_cnt", 32'(a_cnt), 0);
    chk("drain2_ov", 32'(a_ov), 0);

    // simultaneous push/pop at count 1, then at full
    a_ob = 1; a_iv = 1; a_id = 8'h11;
    step();
    a_ob = 0; a_id = 8'h22;
    step();
    chk("pp1_cnt", 32'(a_cnt), 1);
    chk("pp1_od", 32'(a_od), 32'h22);
    a_ob = 1; a_id = 8'h33;
    step();
    chk("pp_full_cnt", 32'(a_cnt), 2);
    a_ob = 0; a_id = 8'h44;
    #1;
    chk("pp_full_ib", 32'(a_ib), 1);
    step();
    chk("pp_full_pop_cnt", 32'(a_cnt), 1);
    chk("pp_full_pop_od", 32'(a_od), 32'h33);
    a_iv = 0;
    step();
    chk("pp_empty_cnt", 32'(a_cnt), 0);

    // flush with two entries plus a concurrent push
    a_ob = 1; a_iv = 1; a_id = 8'h55;
    step();
    a_id = 8'h66;
    step();
    chk("fl_pre_cnt", 32'(a_cnt), 2);
    a_fl = 1; a_iv = 1; a_id = 8'h77;
    #1;
    chk("fl_same_ov", 32'(a_ov), 0);
    step();
    a_fl = 0; a_iv = 0;
    #1;
    chk("fl_cnt", 32'(a_cnt), 0);
    chk("fl_ov", 32'(a_ov), 0);
    a_ob = 0; a_iv = 1; a_id = 8'h88;
    step();
    chk("fl_after_od", 32'(a_od), 32'h88);
    chk("fl_after_cnt", 32'(a_cnt), 1);
    a_iv = 0;
    step();
    chk("fl_after_empty", 32'(a_cnt), 0);

    // reset mid-stream with two entries
    a_ob = 1; a_iv = 1; a_id = 8'h99;
    step();
    a_id = 8'hAA;
    step();
    chk("mrst_pre_cnt", 32'(a_cnt), 2);
    rstn = 0; a_id = 8'hBB;
    step();
    rstn = 1; a_iv = 0;
    #1;
    chk("mrst_cnt", 32'(a_cnt), 0);
    chk("mrst_ov", 32'(a_ov), 0);
    chk("mrst_ib", 32'(a_ib), 0);
    chk("mrst_od", 32'(a_od), 0);

    // wrap through DEPTH 3 with continuous pops
    b_ob = 0; b_iv = 1;
    for (int k = 1; k <= 10; k++) begin
      b_id = 8'(k);
      step();
      chk($sformatf("wrap_od_%0d", k), 32'(b_od), 32'(k));
      chk($sformatf("wrap_cnt_%0d", k), 32'(b_cnt), 1);
    end
    b_iv = 0;
    step();
    chk("wrap_end_cnt", 32'(b_cnt), 0);
    chk("wrap_end_ov", 32'(b_ov), 0);

    // bypass
    c_ob = 0; c_iv = 1; c_id = 8'h55;
    #1;
    chk("byp_ov", 32'(c_ov), 1);
    chk("byp_od", 32'(c_od), 32'h55);
    step();
    chk("byp_cnt", 32'(c_cnt), 0);
    c_ob = 1; c_id = 8'h56;
    #1;
    chk("byp_busy_ov", 32'(c_ov), 1);
    step();
    chk("byp_busy_cnt", 32'(c_cnt), 1);
    chk("byp_busy_od", 32'(c_od), 32'h56);
    c_ob = 0; c_id = 8'h57;
    #1;
    chk("byp_order_od", 32'(c_od), 32'h56);
    step();
    chk("byp_pp_cnt", 32'(c_cnt), 1);
    chk("byp_pp_od", 32'(c_od), 32'h57);
    c_iv = 0;
    step();
    chk("byp_drain_cnt", 32'(c_cnt), 0);
    c_fl = 1; c_iv = 1; c_id = 8'h58;
    #1;
    chk("byp_fl_ov", 32'(c_ov), 0);
    step();
    c_fl = 0; c_iv = 0;
    #1;
    chk("byp_fl_cnt", 32'(c_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
